// File: rtl/fabric_chk_pkg.sv
// fabric_chk_pkg
//  Shared types and helpers for the fabric loopback checker.
//  - state_t        : checker FSM states (HUNT / LOCK)
//  - BAD_NOT_ONEHOT : BAD_IDX code {msb, fill bit} for an all-zero or multi-bit sample
//  - BAD_TIMEOUT    : BAD_IDX code {msb, fill bit} for a stalled pattern
//  - CNT_W, sat_inc : 16-bit saturating event counters
package fabric_chk_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int unsigned CNT_W = 16;

    // {BAD_IDX msb, value replicated into the low IW bits}
    localparam logic [1:0] BAD_NOT_ONEHOT = 2'b10;
    localparam logic [1:0] BAD_TIMEOUT    = 2'b11;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fabric_din_filter.sv
// fabric_din_filter
//  Resynchronises the looped-back pattern and accepts a value once it has been
//  stable for SETTLE cycles and differs from the previously accepted value.
//  Ports:
//   CLK     in            system clock
//   RESET_N in            asynchronous active-low reset
//   DIN     in  WIDTH     asynchronous pattern input
//   acc     out           one-cycle strobe: v is a newly accepted sample
//   v       out WIDTH     synchronised sample (valid while acc is high)
module fabric_din_filter
    import fabric_chk_pkg::*;
#(
    parameter int unsigned WIDTH  = 62,
    parameter int unsigned SETTLE = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] DIN,
    output logic             acc,
    output logic [WIDTH-1:0] v
);

    localparam int unsigned SW = $clog2(SETTLE + 1);

    logic [WIDTH-1:0] sync1_q, s_q, s_prev_q, last_acc_q;
    logic [SW-1:0]    stab_cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q    <= '0;
            s_q        <= '0;
            s_prev_q   <= '0;
            last_acc_q <= '0;
            stab_cnt_q <= '0;
        end else begin
            sync1_q  <= DIN;
            s_q      <= sync1_q;
            s_prev_q <= s_q;
            // stab_cnt_q = number of cycles s_q has matched its previous value
            if (s_q != s_prev_q) begin
                stab_cnt_q <= SW'(1);
            end else if (stab_cnt_q != SW'(SETTLE)) begin
                stab_cnt_q <= stab_cnt_q + SW'(1);
            end
            if (acc) begin
                last_acc_q <= s_q;
            end
        end
    end

    // s_q == s_prev_q masks the stale saturated count on the first cycle of a new value
    assign acc = (stab_cnt_q == SW'(SETTLE)) && (s_q == s_prev_q) && (s_q != last_acc_q);
    assign v   = s_q;

endmodule

// File: rtl/fabric_loopback_checker.sv
// fabric_loopback_checker
//  Checks a jumpered-back walking-one pattern: one-hot and +1 rotation order.
//  Optional macro FABRIC_CHK_TIMEOUT_EN: drop lock when no sample is accepted
//  for TIMEOUT-1 cycles while locked.
//  Ports:
//   CLK      in            system clock
//   RESET_N  in            asynchronous active-low reset
//   DIN      in  WIDTH     looped-back pattern, asynchronous to CLK
//   CLEAR    in            synchronous clear of counters / BAD_IDX, back to HUNT
//   LOCKED   out           high while in LOCK
//   ERR      out           one-cycle pulse per detected error
//   PASS_CNT out 16        saturating count of in-order samples
//   ERR_CNT  out 16        saturating count of errors
//   BAD_IDX  out IW+1      last offending value: {0,idx} / {1,0..} not one-hot / {1,1..} timeout
module fabric_loopback_checker
    import fabric_chk_pkg::*;
#(
    parameter int unsigned WIDTH   = 62,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 2**26
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [WIDTH-1:0]       DIN,
    input  logic                   CLEAR,
    output logic                   LOCKED,
    output logic                   ERR,
    output logic [CNT_W-1:0]       PASS_CNT,
    output logic [CNT_W-1:0]       ERR_CNT,
    output logic [$clog2(WIDTH):0] BAD_IDX
);

    localparam int unsigned IW = $clog2(WIDTH);

    if (SETTLE < 1 || TIMEOUT < 2) begin : g_param_check
        $error("fabric_loopback_checker: SETTLE must be >= 1 and TIMEOUT >= 2");
    end

    logic             acc;
    logic [WIDTH-1:0] v;

    fabric_din_filter #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) u_filter (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .DIN     (DIN),
        .acc     (acc),
        .v       (v)
    );

    // Decode: one-hot flag, bit position and its rotation successor
    logic          oh;
    logic [IW-1:0] idx, idx_nxt;

    always_comb begin
        oh  = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IW'(i);
        end
        idx_nxt = (idx == IW'(WIDTH - 1)) ? '0 : idx + IW'(1);
    end

    state_t           state_q;
    logic             locked_q, err_q;
    logic [CNT_W-1:0] pass_cnt_q, err_cnt_q;
    logic [IW:0]      bad_idx_q;
    logic [IW-1:0]    exp_q;

`ifdef FABRIC_CHK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT);
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_hit;
    assign tmo_hit = (state_q == LOCK) && (tmo_cnt_q == TW'(TIMEOUT - 1));
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= HUNT;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            bad_idx_q  <= '0;
            exp_q      <= '0;
`ifdef FABRIC_CHK_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            err_q <= 1'b0;
`ifdef FABRIC_CHK_TIMEOUT_EN
            // Runs only while locked; any accepted sample restarts it
            if (state_q == LOCK && !acc && !tmo_hit) tmo_cnt_q <= tmo_cnt_q + TW'(1);
            else                                     tmo_cnt_q <= '0;
`endif
            if (CLEAR) begin
                // A coincident acc is dropped; the filter still records it as accepted
                state_q    <= HUNT;
                locked_q   <= 1'b0;
                pass_cnt_q <= '0;
                err_cnt_q  <= '0;
                bad_idx_q  <= '0;
            end else if (acc) begin
                case (state_q)
                    HUNT: begin
                        if (oh) begin
                            exp_q    <= idx_nxt;
                            state_q  <= LOCK;
                            locked_q <= 1'b1;
                        end
                    end
                    LOCK: begin
                        if (oh && idx == exp_q) begin
                            pass_cnt_q <= sat_inc(pass_cnt_q);
                            exp_q      <= idx_nxt;
                        end else if (oh && idx == '0) begin
                            // Upstream pattern restarted from bit 0: resync silently
                            exp_q <= idx_nxt;
                        end else begin
                            err_q     <= 1'b1;
                            err_cnt_q <= sat_inc(err_cnt_q);
                            bad_idx_q <= oh ? {1'b0, idx}
                                            : {BAD_NOT_ONEHOT[1], {IW{BAD_NOT_ONEHOT[0]}}};
                            state_q   <= HUNT;
                            locked_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
`ifdef FABRIC_CHK_TIMEOUT_EN
            end else if (tmo_hit) begin
                err_q     <= 1'b1;
                err_cnt_q <= sat_inc(err_cnt_q);
                bad_idx_q <= {BAD_TIMEOUT[1], {IW{BAD_TIMEOUT[0]}}};
                state_q   <= HUNT;
                locked_q  <= 1'b0;
`endif
            end
        end
    end

    assign LOCKED   = locked_q;
    assign ERR      = err_q;
    assign PASS_CNT = pass_cnt_q;
    assign ERR_CNT  = err_cnt_q;
    assign BAD_IDX  = bad_idx_q;

endmodule

// File: tb/tb_fabric_loopback_checker.sv
// tb_fabric_loopback_checker
//  Directed bench for fabric_loopback_checker at WIDTH=8, SETTLE=4, TIMEOUT=64.
//  Honours FABRIC_CHK_TIMEOUT_EN for the stalled-pattern step.
module tb_fabric_loopback_checker;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [7:0]  DIN = 8'h00;
    logic        CLEAR = 1'b0;
    logic        LOCKED, ERR;
    logic [15:0] PASS_CNT, ERR_CNT;
    logic [3:0]  BAD_IDX;

    int n_assert = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int err_base = 0;

    fabric_loopback_checker #(
        .WIDTH   (WIDTH),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .DIN      (DIN),
        .CLEAR    (CLEAR),
        .LOCKED   (LOCKED),
        .ERR      (ERR),
        .PASS_CNT (PASS_CNT),
        .ERR_CNT  (ERR_CNT),
        .BAD_IDX  (BAD_IDX)
    );

    always #5 CLK = ~CLK;

    // Cycles on which ERR was high
    always @(posedge CLK) if (ERR === 1'b1) err_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a new value and leave it long enough to settle and be acted on
    task automatic drive(input logic [7:0] val);
        @(negedge CLK);
        DIN = val;
        repeat (20) @(negedge CLK);
    endtask

    task automatic err_pulses(input string tag, input int exp);
        check(tag, err_seen - err_base, exp);
        err_base = err_seen;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_locked", LOCKED, 0);
        check("rst_err", ERR, 0);
        check("rst_pass", PASS_CNT, 0);
        check("rst_errcnt", ERR_CNT, 0);
        check("rst_bad", BAD_IDX, 0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("idle_locked", LOCKED, 0);

        // Walking one 1,2,..,128 then 1,2: lock on first, 9 passes
        drive(8'h01);
        check("walk_lock", LOCKED, 1);
        check("walk_pass0", PASS_CNT, 0);
        for (int i = 1; i < 8; i++) drive(8'(1 << i));
        drive(8'h01);
        drive(8'h02);
        check("walk_pass", PASS_CNT, 9);
        check("walk_errcnt", ERR_CNT, 0);
        check("walk_locked", LOCKED, 1);
        err_pulses("walk_errpulse", 0);

        // Expecting idx 3, present idx 5
        drive(8'h04);
        check("pos_pass", PASS_CNT, 10);
        drive(8'h20);
        err_pulses("pos_errpulse", 1);
        check("pos_errcnt", ERR_CNT, 1);
        check("pos_bad", BAD_IDX, 4'b0101);
        check("pos_locked", LOCKED, 0);
        drive(8'h40);
        check("relock", LOCKED, 1);
        check("relock_pass", PASS_CNT, 10);

        // All-zero while locked, then multi-bit while hunting
        drive(8'h00);
        err_pulses("zero_errpulse", 1);
        check("zero_bad", BAD_IDX, 4'b1000);
        check("zero_locked", LOCKED, 0);
        check("zero_errcnt", ERR_CNT, 2);
        drive(8'h11);
        err_pulses("multi_errpulse", 0);
        check("multi_errcnt", ERR_CNT, 2);
        check("multi_locked", LOCKED, 0);
        check("multi_bad", BAD_IDX, 4'b1000);

        // Lock at exp=5, then restart from bit 0
        drive(8'h08);
        drive(8'h10);
        check("rs_pass_pre", PASS_CNT, 11);
        drive(8'h01);
        err_pulses("rs_errpulse", 0);
        check("rs_pass", PASS_CNT, 11);
        check("rs_locked", LOCKED, 1);
        drive(8'h02);
        check("rs_exp1", PASS_CNT, 12);
        drive(8'h04);
        check("rs_exp2", PASS_CNT, 13);

        // Two-cycle glitch back to the same value
        @(negedge CLK);
        DIN = 8'h08;
        repeat (2) @(negedge CLK);
        DIN = 8'h04;
        repeat (20) @(negedge CLK);
        check("gl_pass", PASS_CNT, 13);
        check("gl_errcnt", ERR_CNT, 2);
        check("gl_locked", LOCKED, 1);
        err_pulses("gl_errpulse", 0);

        // Stalled pattern
        repeat (80) @(negedge CLK);
`ifdef FABRIC_CHK_TIMEOUT_EN
        err_pulses("tmo_errpulse", 1);
        check("tmo_errcnt", ERR_CNT, 3);
        check("tmo_bad", BAD_IDX, 4'b1111);
        check("tmo_locked", LOCKED, 0);
`else
        err_pulses("hold_errpulse", 0);
        check("hold_locked", LOCKED, 1);
        check("hold_errcnt", ERR_CNT, 2);
`endif

        // CLEAR on the exact cycle acc is high (change + 6 negedges)
        @(negedge CLK);
        DIN = 8'h08;
        repeat (6) @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        repeat (20) @(negedge CLK);
        check("clr_pass", PASS_CNT, 0);
        check("clr_errcnt", ERR_CNT, 0);
        check("clr_bad", BAD_IDX, 0);
        check("clr_locked", LOCKED, 0);
        err_pulses("clr_errpulse", 0);
        drive(8'h10);
        check("clr_relock", LOCKED, 1);
        check("clr_relock_pass", PASS_CNT, 0);

        // Wrong position at top bit, relock, one pass
        drive(8'h80);
        check("top_bad", BAD_IDX, 4'b0111);
        check("top_errcnt", ERR_CNT, 1);
        drive(8'h01);
        drive(8'h02);
        check("pre_rst_pass", PASS_CNT, 1);
        check("pre_rst_locked", LOCKED, 1);

        // Asynchronous reset mid-cycle
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("arst_locked", LOCKED, 0);
        check("arst_err", ERR, 0);
        check("arst_pass", PASS_CNT, 0);
        check("arst_errcnt", ERR_CNT, 0);
        check("arst_bad", BAD_IDX, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (20) @(negedge CLK);
        check("post_rst_lock", LOCKED, 1);
        check("post_rst_pass", PASS_CNT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
